// File: rtl/burst_addr_ctrl_if.sv
// Request/beat bus between the burst requester, the address controller and the MRAM sequencer.
// master = requester/sequencer side, slave = burst_addr_ctrl.
interface burst_addr_ctrl_if #(
    parameter int ADDR_WIDTH    = 20,
    parameter int COUNTER_WIDTH = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic [ADDR_WIDTH-1:0]    req_addr;
    logic [COUNTER_WIDTH-1:0] req_len;
    logic                     req_wr;
    logic                     abort;
    logic                     beat_valid;
    logic                     beat_ready;
    logic [ADDR_WIDTH-1:0]    beat_addr;
    logic [COUNTER_WIDTH-1:0] beat_idx;
    logic                     beat_wr;
    logic                     beat_last;
    logic                     busy;
    logic                     done;
    logic                     aborted;

    modport master (
        output req_valid, req_addr, req_len, req_wr, abort, beat_ready,
        input  req_ready, beat_valid, beat_addr, beat_idx, beat_wr, beat_last,
               busy, done, aborted
    );

    modport slave (
        input  req_valid, req_addr, req_len, req_wr, abort, beat_ready,
        output req_ready, beat_valid, beat_addr, beat_idx, beat_wr, beat_last,
               busy, done, aborted
    );
endinterface

// File: rtl/burst_addr_ctrl.sv
// Burst address controller: accepts one burst request and issues base+index beat
// addresses (wrapping modulo 2^ADDR_WIDTH), ending with a one-cycle done pulse.
module burst_addr_ctrl #(
    parameter int ADDR_WIDTH    = 20,
    parameter int COUNTER_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    burst_addr_ctrl_if.slave  bus_io
);
    typedef enum logic [1:0] {IDLE, BURST, DONE} state_e;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    base_q, base_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [COUNTER_WIDTH-1:0] len_q, len_d;
    logic [COUNTER_WIDTH-1:0] idx_q, idx_d;
    logic [COUNTER_WIDTH-1:0] idx_inc;
    logic                     wr_q, wr_d;
    logic                     aborted_q, aborted_d;
    logic                     req_fire, beat_fire, is_last;

    assign is_last   = (idx_q == len_q);
    assign idx_inc   = idx_q + COUNTER_WIDTH'(1);
    assign req_fire  = (state_q == IDLE) && bus_io.req_valid;
    assign beat_fire = (state_q == BURST) && bus_io.beat_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            aborted_q <= aborted_d;
        end
    end

    // Abort takes priority over a last-beat completion; either way the burst ends.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus_io.req_valid) state_d = BURST;
            BURST:   if (bus_io.abort || (beat_fire && is_last)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        base_d    = base_q;
        addr_d    = addr_q;
        len_d     = len_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        aborted_d = aborted_q;
        if (req_fire) begin
            base_d    = bus_io.req_addr;
            addr_d    = bus_io.req_addr;
            len_d     = bus_io.req_len;
            wr_d      = bus_io.req_wr;
            idx_d     = '0;
            aborted_d = 1'b0;
        end else if (state_q == BURST) begin
            if (bus_io.abort) begin
                aborted_d = 1'b1;
            end else if (beat_fire && !is_last) begin
                // Address is pre-computed so the next beat follows with no bubble.
                idx_d  = idx_inc;
                addr_d = base_q + {{(ADDR_WIDTH-COUNTER_WIDTH){1'b0}}, idx_inc};
            end
        end else if (state_q == DONE) begin
            aborted_d = 1'b0;
        end
    end

    always_comb begin
        bus_io.req_ready  = (state_q == IDLE);
        bus_io.beat_valid = (state_q == BURST);
        bus_io.busy       = (state_q != IDLE);
        bus_io.done       = (state_q == DONE);
        bus_io.aborted    = (state_q == DONE) && aborted_q;
        bus_io.beat_last  = (state_q == BURST) && is_last;
        bus_io.beat_addr  = addr_q;
        bus_io.beat_idx   = idx_q;
        bus_io.beat_wr    = wr_q;
    end
endmodule

// File: tb/tb_burst_addr_ctrl.sv
// Directed, table-driven check of burst_addr_ctrl plus hand-written reset and
// abort-with-accept sequences.
module tb_burst_addr_ctrl;
    localparam int AW = 20;
    localparam int CW = 4;

    typedef struct {
        logic          rv;
        logic [AW-1:0] ra;
        logic [CW-1:0] rl;
        logic          rw;
        logic          ab;
        logic          br;
        logic          e_rr;
        logic          e_bv;
        logic [AW-1:0] e_addr;
        logic [CW-1:0] e_idx;
        logic          e_wr;
        logic          e_last;
        logic          e_busy;
        logic          e_done;
        logic          e_ab;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    burst_addr_ctrl_if #(.ADDR_WIDTH(AW), .COUNTER_WIDTH(CW)) bus ();

    burst_addr_ctrl #(.ADDR_WIDTH(AW), .COUNTER_WIDTH(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rv, input logic [AW-1:0] ra, input logic [CW-1:0] rl,
        input logic rw, input logic ab, input logic br,
        input logic rr, input logic bv, input logic [AW-1:0] addr,
        input logic [CW-1:0] idx, input logic wr, input logic last,
        input logic busy, input logic done, input logic abt);
        vec_t v;
        v.rv = rv; v.ra = ra; v.rl = rl; v.rw = rw; v.ab = ab; v.br = br;
        v.e_rr = rr; v.e_bv = bv; v.e_addr = addr; v.e_idx = idx; v.e_wr = wr;
        v.e_last = last; v.e_busy = busy; v.e_done = done; v.e_ab = abt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.req_valid  = v.rv;
        bus.req_addr   = v.ra;
        bus.req_len    = v.rl;
        bus.req_wr     = v.rw;
        bus.abort      = v.ab;
        bus.beat_ready = v.br;
    endtask

    task automatic check(input string name, input vec_t v);
        logic ok;
        n_vec++;
        ok = (bus.req_ready === v.e_rr) && (bus.beat_valid === v.e_bv) &&
             (bus.beat_addr === v.e_addr) && (bus.beat_idx === v.e_idx) &&
             (bus.beat_wr === v.e_wr) && (bus.beat_last === v.e_last) &&
             (bus.busy === v.e_busy) && (bus.done === v.e_done) &&
             (bus.aborted === v.e_ab);
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got rr=%b bv=%b addr=%h idx=%0d wr=%b last=%b busy=%b done=%b ab=%b, want rr=%b bv=%b addr=%h idx=%0d wr=%b last=%b busy=%b done=%b ab=%b",
                     name, bus.req_ready, bus.beat_valid, bus.beat_addr, bus.beat_idx,
                     bus.beat_wr, bus.beat_last, bus.busy, bus.done, bus.aborted,
                     v.e_rr, v.e_bv, v.e_addr, v.e_idx, v.e_wr, v.e_last,
                     v.e_busy, v.e_done, v.e_ab);
        end else begin
            $display("%s: rr=%b bv=%b addr=%h idx=%0d last=%b done=%b ab=%b ok",
                     name, bus.req_ready, bus.beat_valid, bus.beat_addr, bus.beat_idx,
                     bus.beat_last, bus.done, bus.aborted);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        vec_t v;

        // Single-beat write burst.
        vecs.push_back(mk(1, 'h00010, 0, 1, 0, 1,  1, 0, 'h00000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,        0, 1, 'h00010, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,        0, 0, 'h00010, 0, 1, 0, 1, 1, 0));
        // Back in IDLE: accept len=3 read burst; beat_ready toggles 1,0,1,0...
        vecs.push_back(mk(1, 'h00100, 3, 0, 0, 0,  1, 0, 'h00010, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            a = 20'h00100 + AW'(i);
            vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, a, CW'(i), 0, i == 3, 1, 0, 0));
            if (i < 3)
                vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, a + 20'h1, CW'(i + 1), 0, i == 2, 1, 0, 0));
        end
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,        0, 0, 'h00103, 3, 0, 0, 1, 1, 0));
        // Address wrap at the top of the space.
        vecs.push_back(mk(1, 'hFFFFE, 3, 1, 0, 1,  1, 0, 'h00103, 3, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            a = 20'hFFFFE + AW'(i);
            vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, a, CW'(i), 1, i == 3, 1, 0, 0));
        end
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,        0, 0, 'h00001, 3, 1, 0, 1, 1, 0));
        // Maximum length burst, req_valid held high and ignored throughout.
        vecs.push_back(mk(1, 'h00000, 15, 0, 0, 1, 1, 0, 'h00001, 3, 1, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(1, 'h55555, 2, 1, 0, 1, 0, 1, AW'(i), CW'(i), 0, i == 15, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,        0, 0, 'h0000F, 15, 0, 0, 1, 1, 0));
        // len=7 burst aborted after the third accepted beat.
        vecs.push_back(mk(1, 'h00200, 7, 1, 0, 1,  1, 0, 'h0000F, 15, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 20'h00200 + AW'(i), CW'(i), 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0,        0, 1, 'h00203, 3, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,        0, 0, 'h00203, 3, 1, 0, 1, 1, 1));
        // abort in IDLE has no effect.
        vecs.push_back(mk(0, 0, 0, 0, 1, 1,        1, 0, 'h00203, 3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1,        1, 0, 'h00203, 3, 1, 0, 0, 0, 0));

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        check("reset_held", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k]);
            check($sformatf("vec %0d", k), vecs[k]);
        end

        // Asynchronous reset in the middle of a len=7 burst.
        @(negedge clk);
        drive(mk(1, 'h00300, 7, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("rst_pre_beat0", mk(0, 0, 0, 0, 0, 1, 0, 1, 'h00300, 0, 1, 0, 1, 0, 0));
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async", mk(0, 0, 0, 0, 0, 1, 1, 0, 'h00000, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        drive(mk(1, 'h00ABC, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("rst_released", mk(0, 0, 0, 0, 0, 0, 1, 0, 'h00000, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("post_rst_beat0", mk(0, 0, 0, 0, 0, 0, 0, 1, 'h00ABC, 0, 0, 0, 1, 0, 0));

        // Abort on the same edge as an accepted beat: abort wins, no more beats.
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("abort_accept_hold", mk(0, 0, 0, 0, 1, 1, 0, 1, 'h00ABC, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("abort_accept_done", mk(0, 0, 0, 0, 0, 1, 0, 0, 'h00ABC, 0, 0, 0, 1, 1, 1));
        @(negedge clk);
        v = mk(0, 0, 0, 0, 0, 1, 1, 0, 'h00ABC, 0, 0, 0, 0, 0, 0);
        check("abort_accept_idle", v);
        @(negedge clk);
        check("abort_accept_still_idle", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
